// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_pkg
// Brief    : Shared matrix widths, streamer state encoding and packed-matrix
//            slice helper used by both the load and the result-return paths.
// Revision : 1.0 - initial release
// ============================================================================
package mat_pkg;

    localparam int WIDTH    = 32;
    localparam int N        = 3;
    localparam int SEND_DET = 1;
    localparam int NWORDS   = N*N + SEND_DET;
    localparam int IDX_W    = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Word 0 occupies the MSBs of a packed vector holding COUNT words.
    function automatic int elem_lsb(input int idx, input int count, input int width);
        return (count - 1 - idx) * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer_if
// Brief    : Valid/ready word stream carrying matrix results to the consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_result_streamer_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_idx,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mat_word_sel.sv
`default_nettype none
// ============================================================================
// Module   : mat_word_sel
// Brief    : Combinational word mux over a packed bank (word 0 in the MSBs).
// Revision : 1.0 - initial release
// ============================================================================
module mat_word_sel #(
    parameter int WIDTH     = 32,
    parameter int NUM_WORDS = 10,
    parameter int IDX_W     = 4
) (
    input  wire [NUM_WORDS*WIDTH-1:0] i_bank,
    input  wire [IDX_W-1:0]           i_idx,
    output logic [WIDTH-1:0]          o_word
);
    import mat_pkg::*;

    logic [WIDTH-1:0] w_words [NUM_WORDS];

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        assign w_words[gi] = i_bank[elem_lsb(gi, NUM_WORDS, WIDTH) +: WIDTH];
    end

    // Indices past the bank read as zero so a one-past-the-end lookahead is harmless.
    always_comb begin
        o_word = '0;
        if (int'(i_idx) < NUM_WORDS) begin
            o_word = w_words[i_idx];
        end
    end
endmodule
`default_nettype wire

// File: rtl/mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer
// Brief    : Captures the parallel result matrix and determinant, then streams
//            them out one word per beat over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module mat_result_streamer #(
    parameter int WIDTH    = mat_pkg::WIDTH,
    parameter int N        = mat_pkg::N,
    parameter int SEND_DET = mat_pkg::SEND_DET
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   start,
    input  wire [N*N*WIDTH-1:0]   MatrixIn,
    input  wire [WIDTH-1:0]       det_in,
    mat_result_streamer_if.master strm,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           LED
);
    import mat_pkg::*;

    localparam int               c_nwords   = N*N + SEND_DET;
    localparam int               c_nbank    = N*N + 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(c_nwords - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_nbank*WIDTH-1:0]   r_bank;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic [WIDTH-1:0]           r_data;
    logic [WIDTH-1:0]           w_data_nxt;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       w_capture;
    logic [c_nbank*WIDTH-1:0]   w_sel_bank;
    logic [IDX_W-1:0]           w_sel_idx;
    logic [WIDTH-1:0]           w_word;
    logic [15:0]                w_led_src;

    // On capture the first word comes straight from the inputs; otherwise look one ahead.
    assign w_capture  = (r_state == ST_IDLE) && start;
    assign w_sel_bank = w_capture ? {MatrixIn, det_in} : r_bank;
    assign w_sel_idx  = w_capture ? '0 : r_idx + IDX_W'(1);

    mat_word_sel #(
        .WIDTH     (WIDTH),
        .NUM_WORDS (c_nbank),
        .IDX_W     (IDX_W)
    ) u_word_sel (
        .i_bank (w_sel_bank),
        .i_idx  (w_sel_idx),
        .o_word (w_word)
    );

    if (WIDTH >= 16) begin : g_led_full
        assign w_led_src = r_data[15:0];
    end else begin : g_led_narrow
        assign w_led_src = 16'(r_data);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_bank  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_bank <= {MatrixIn, det_in};
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_data_nxt     = r_data;
        w_done_nxt     = 1'b0;
        strm.out_valid = 1'b0;
        busy           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                    w_data_nxt  = w_word;
                end
            end
            ST_SEND: begin
                strm.out_valid = 1'b1;
                busy           = 1'b1;
                if (strm.out_ready) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_data_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + IDX_W'(1);
                        w_data_nxt = w_word;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign strm.out_data = r_data;
    assign strm.out_idx  = r_idx;
    assign strm.out_last = (r_state == ST_SEND) && (r_idx == c_last_idx);
    assign done          = r_done;
    assign LED           = (r_state == ST_SEND) ? w_led_src : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_result_streamer
// Brief    : Self-checking bench for the matrix result streamer, with and
//            without the trailing determinant word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_result_streamer;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rdy   = 1'b1;
    logic [287:0] mat   = '0;
    logic [31:0]  det   = '0;
    logic         busy_a, done_a, busy_b, done_b;
    logic [15:0]  led_a, led_b;

    mat_result_streamer_if #(.WIDTH(32), .IDX_W(4)) if_a ();
    mat_result_streamer_if #(.WIDTH(32), .IDX_W(4)) if_b ();
    assign if_a.out_ready = rdy;
    assign if_b.out_ready = rdy;

    mat_result_streamer #(.WIDTH(32), .N(3), .SEND_DET(1)) dut_a (
        .clk(clk), .reset(rst_n), .start(start), .MatrixIn(mat), .det_in(det),
        .strm(if_a), .busy(busy_a), .done(done_a), .LED(led_a)
    );

    mat_result_streamer #(.WIDTH(32), .N(3), .SEND_DET(0)) dut_b (
        .clk(clk), .reset(rst_n), .start(start), .MatrixIn(mat), .det_in(det),
        .strm(if_b), .busy(busy_b), .done(done_b), .LED(led_b)
    );

    always #5 clk = ~clk;

    // Frame model: a captured list of expected words and a pointer to the head.
    logic [31:0] m_frame [2][10];
    bit          m_act  [2];
    int          m_ptr  [2];
    bit          m_done [2];

    function automatic int nwords(input int d);
        return (d == 0) ? 10 : 9;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d]  <= 1'b0;
                m_ptr[d]  <= 0;
                m_done[d] <= 1'b0;
            end else begin
                m_done[d] <= 1'b0;
                if (m_act[d]) begin
                    if (rdy) begin
                        if (m_ptr[d] == nwords(d) - 1) begin
                            m_act[d]  <= 1'b0;
                            m_ptr[d]  <= 0;
                            m_done[d] <= 1'b1;
                        end else begin
                            m_ptr[d] <= m_ptr[d] + 1;
                        end
                    end
                end else if (start) begin
                    for (int k = 0; k < 9; k++) m_frame[d][k] <= mat[(8-k)*32 +: 32];
                    m_frame[d][9] <= det;
                    m_act[d]      <= 1'b1;
                    m_ptr[d]      <= 0;
                end
            end
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] log_a [$];
    logic [31:0] log_b [$];
    int          cyc_a [$];
    int          n_last_a = 0, last_idx_a = 0, n_last_b = 0, last_idx_b = 0, done_cyc_a = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_dut(input int d, input string p, input logic v, input logic [31:0] data,
                             input logic [3:0] idx, input logic last, input logic bsy,
                             input logic dn, input logic [15:0] led);
        logic [31:0] w;
        w = m_frame[d][m_ptr[d]];
        if (!rst_n) begin
            chk({p, "_rst_valid"}, v, 0);
            chk({p, "_rst_data"}, data, 0);
            chk({p, "_rst_idx"}, idx, 0);
            chk({p, "_rst_last"}, last, 0);
            chk({p, "_rst_busy"}, bsy, 0);
            chk({p, "_rst_done"}, dn, 0);
            chk({p, "_rst_led"}, led, 0);
        end else begin
            chk({p, "_valid"}, v, m_act[d]);
            chk({p, "_busy"}, bsy, m_act[d]);
            chk({p, "_done"}, dn, m_done[d]);
            chk({p, "_last"}, last, m_act[d] && (m_ptr[d] == nwords(d) - 1));
            chk({p, "_idx"}, idx, m_act[d] ? m_ptr[d] : 0);
            chk({p, "_led"}, led, m_act[d] ? w[15:0] : 16'h0000);
            if (m_act[d]) chk({p, "_data"}, data, w);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        check_dut(0, "a", if_a.out_valid, if_a.out_data, if_a.out_idx, if_a.out_last, busy_a, done_a, led_a);
        check_dut(1, "b", if_b.out_valid, if_b.out_data, if_b.out_idx, if_b.out_last, busy_b, done_b, led_b);
        if (rst_n && if_a.out_valid && rdy) begin
            log_a.push_back(if_a.out_data);
            cyc_a.push_back(cyc);
            if (if_a.out_last) begin n_last_a++; last_idx_a = int'(if_a.out_idx); end
        end
        if (rst_n && if_b.out_valid && rdy) begin
            log_b.push_back(if_b.out_data);
            if (if_b.out_last) begin n_last_b++; last_idx_b = int'(if_b.out_idx); end
        end
        if (done_a) done_cyc_a = cyc;
    end

    task automatic load(input int base, input logic [31:0] d);
        for (int k = 0; k < 9; k++) mat[(8-k)*32 +: 32] = 32'(base + k);
        det = d;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_b.delete(); cyc_a.delete();
        n_last_a = 0; n_last_b = 0; last_idx_a = 0; last_idx_b = 0;
    endtask

    task automatic pulse_start(output int st);
        @(posedge clk); #1 start = 1'b1; st = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #1;
            if (done_a) seen = 1'b1;
        end
        chk(nm, seen, 1);
    endtask

    initial begin
        int st;
        bit bp_seen;
        bit reached;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", if_a.out_valid, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_led", led_a, 0);
        rst_n = 1'b1;

        // Full rate: elements 1..9 and a negative determinant.
        load(1, 32'hFFFF_FFF6); rdy = 1'b1; clear_logs();
        pulse_start(st);
        wait_done("fr_done", 30);
        chk("fr_beats_a", log_a.size(), 10);
        if (log_a.size() == 10) begin
            chk("fr_first", log_a[0], 32'd1);
            chk("fr_m22", log_a[8], 32'd9);
            chk("fr_det", log_a[9], 32'hFFFF_FFF6);
            chk("fr_latency", cyc_a[0], st + 2);
            chk("fr_consec", cyc_a[9] - cyc_a[0], 9);
            chk("fr_done_lat", done_cyc_a - cyc_a[9], 1);
        end
        chk("fr_nlast", n_last_a, 1);
        chk("fr_last_idx", last_idx_a, 9);
        chk("b_beats", log_b.size(), 9);
        if (log_b.size() == 9) chk("b_last_word", log_b[8], 32'd9);
        chk("b_nlast", n_last_b, 1);
        chk("b_last_idx", last_idx_b, 8);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        load(16, 32'hABCD_1234); clear_logs();
        pulse_start(st);
        bp_seen = 1'b0;
        for (int i = 0; i < 100 && !bp_seen; i++) begin
            rdy = ((i % 4) == 0) || ((i % 4) == 3);
            @(negedge clk); #1;
            if (done_a) bp_seen = 1'b1;
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        chk("bp_done", bp_seen, 1);
        chk("bp_beats", log_a.size(), 10);
        if (log_a.size() == 10) begin
            chk("bp_w0", log_a[0], 32'd16);
            chk("bp_w5", log_a[5], 32'd21);
            chk("bp_det", log_a[9], 32'hABCD_1234);
        end
        chk("bp_b_beats", log_b.size(), 9);

        // Start while busy must not restart or overwrite the frame.
        load(101, 32'd110); clear_logs();
        pulse_start(st);
        for (int i = 0; i < 20 && log_a.size() < 3; i++) begin
            @(negedge clk); #1;
        end
        chk("sb_reach3", log_a.size(), 3);
        load(201, 32'd210); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("sb_done", 30);
        chk("sb_beats", log_a.size(), 10);
        if (log_a.size() == 10) begin
            chk("sb_w3", log_a[3], 32'd104);
            chk("sb_det", log_a[9], 32'd110);
        end
        @(negedge clk); #1;
        chk("sb_no_restart", if_a.out_valid, 0);

        // Back-to-back: start raised during the done cycle.
        load(1, 32'hFFFF_FFF6); clear_logs();
        pulse_start(st);
        wait_done("bb_done1", 30);
        load(31, 32'h0000_0040); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1;
        chk("bb_valid", if_a.out_valid, 1);
        chk("bb_word0", if_a.out_data, 32'd31);
        chk("bb_idx0", if_a.out_idx, 0);
        wait_done("bb_done2", 30);
        chk("bb_beats", log_a.size(), 20);
        if (log_a.size() == 20) begin
            chk("bb_f2_first", log_a[10], 32'd31);
            chk("bb_f2_det", log_a[19], 32'h0000_0040);
        end

        // Reset mid-frame at idx 4, then a fresh frame from idx 0.
        load(51, 32'd60); clear_logs();
        pulse_start(st);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk); #1;
            if (if_a.out_idx == 4'd4) reached = 1'b1;
        end
        chk("rm_reach_idx4", reached, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", if_a.out_valid, 0);
        chk("rm_data", if_a.out_data, 0);
        chk("rm_idx", if_a.out_idx, 0);
        chk("rm_busy", busy_a, 0);
        chk("rm_led", led_a, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rm_no_done", done_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        load(71, 32'd80); clear_logs();
        pulse_start(st);
        @(negedge clk); #1;
        chk("rm_restart_valid", if_a.out_valid, 1);
        chk("rm_restart_idx", if_a.out_idx, 0);
        chk("rm_restart_data", if_a.out_data, 32'd71);
        wait_done("rm_done", 30);
        chk("rm_beats", log_a.size(), 10);
        if (log_a.size() == 10) chk("rm_det", log_a[9], 32'd80);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
